// File: rtl/st2_cart_loader.sv
// Download-side loader: steers the HPS ioctl byte stream into the BIOS ROM or the
// cartridge RAM, parsing .st2 headers and holding the CPU in reset while a download runs.
module st2_cart_loader #(
    parameter logic [7:0] BIOS_INDEX = 8'd0,
    parameter logic [7:0] BIN_INDEX  = 8'd1,
    parameter logic [7:0] ST2_INDEX  = 8'd2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        bios_we,
    output logic        cart_we,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        cpu_reset,
    output logic        cart_loaded,
    output logic        st2_error
);

    typedef enum logic [2:0] {IDLE, RAW, HDR, BODY, SKIP, FLUSH} state_t;

    state_t      state_q, state_d;
    logic        dl_q;
    logic        is_bios_q, is_bios_d;
    logic        bad_q, bad_d;
    logic [7:0]  nblk_q, nblk_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic        bios_we_q, bios_we_d;
    logic        cart_we_q, cart_we_d;
    logic [11:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_din_q, mem_din_d;
    logic        cart_loaded_q, cart_loaded_d;
    logic        st2_error_q, st2_error_d;

    // Only the low nibble of each page entry selects a 256-byte slot in the 4 KB RAM.
    logic [3:0]  page_mem_q [0:63];
    logic        page_we;
    logic [3:0]  page_rd;

    logic        rise, fall, wr;
    logic [5:0]  blk;
    logic [7:0]  magic_byte;

    assign rise    = ioctl_download & ~dl_q;
    assign fall    = ~ioctl_download & dl_q;
    assign wr      = ioctl_wr & ioctl_download;
    assign blk     = ioctl_addr[13:8];
    assign page_rd = page_mem_q[blk - 6'd1];

    always_comb begin
        case (ioctl_addr[1:0])
            2'd0:    magic_byte = 8'h52;
            2'd1:    magic_byte = 8'h43;
            2'd2:    magic_byte = 8'h41;
            default: magic_byte = 8'h32;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        is_bios_d     = is_bios_q;
        bad_d         = bad_q;
        nblk_d        = nblk_q;
        flush_cnt_d   = 4'd0;
        bios_we_d     = 1'b0;
        cart_we_d     = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        cart_loaded_d = cart_loaded_q;
        st2_error_d   = st2_error_q;
        page_we       = 1'b0;

        case (state_q)
            IDLE, FLUSH: begin
                // A new download start abandons any flush still counting.
                if (rise) begin
                    if (ioctl_index == BIOS_INDEX || ioctl_index == BIN_INDEX) begin
                        state_d       = RAW;
                        is_bios_d     = (ioctl_index == BIOS_INDEX);
                        cart_loaded_d = 1'b0;
                        st2_error_d   = 1'b0;
                    end else if (ioctl_index == ST2_INDEX) begin
                        state_d       = HDR;
                        bad_d         = 1'b0;
                        cart_loaded_d = 1'b0;
                        st2_error_d   = 1'b0;
                    end else begin
                        state_d = SKIP;
                    end
                end else if (state_q == FLUSH) begin
                    if (flush_cnt_q == 4'd15) state_d = IDLE;
                    else flush_cnt_d = flush_cnt_q + 4'd1;
                end
            end
            RAW: begin
                if (fall) begin
                    state_d       = FLUSH;
                    cart_loaded_d = ~is_bios_q;
                end else if (wr) begin
                    mem_din_d = ioctl_dout;
                    if (is_bios_q) begin
                        bios_we_d  = (ioctl_addr < 25'd2048);
                        mem_addr_d = {1'b0, ioctl_addr[10:0]};
                    end else begin
                        cart_we_d  = (ioctl_addr < 25'd3072);
                        mem_addr_d = 12'h400 + ioctl_addr[11:0];
                    end
                end
            end
            HDR: begin
                if (fall) begin
                    state_d     = FLUSH;
                    st2_error_d = 1'b1;
                end else if (wr && ioctl_addr < 25'd256) begin
                    if (ioctl_addr < 25'd4 && ioctl_dout != magic_byte) bad_d = 1'b1;
                    if (ioctl_addr == 25'd4) nblk_d = ioctl_dout;
                    page_we = (ioctl_addr[7:6] == 2'b01);
                    if (ioctl_addr == 25'd255) begin
                        if (bad_q || nblk_q < 8'd2) begin
                            state_d     = SKIP;
                            st2_error_d = 1'b1;
                        end else begin
                            state_d = BODY;
                        end
                    end
                end
            end
            BODY: begin
                if (fall) begin
                    state_d       = FLUSH;
                    cart_loaded_d = 1'b1;
                end else if (wr && ioctl_addr < 25'd16384 && blk != 6'd0
                             && {2'b00, blk} < nblk_q) begin
                    cart_we_d  = 1'b1;
                    mem_addr_d = {page_rd, ioctl_addr[7:0]};
                    mem_din_d  = ioctl_dout;
                end
            end
            SKIP: begin
                if (fall) state_d = FLUSH;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            // Treat the line as already high so a download in flight across reset is ignored.
            dl_q          <= 1'b1;
            is_bios_q     <= 1'b0;
            bad_q         <= 1'b0;
            nblk_q        <= 8'd0;
            flush_cnt_q   <= 4'd0;
            bios_we_q     <= 1'b0;
            cart_we_q     <= 1'b0;
            mem_addr_q    <= 12'd0;
            mem_din_q     <= 8'd0;
            cart_loaded_q <= 1'b0;
            st2_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            dl_q          <= ioctl_download;
            is_bios_q     <= is_bios_d;
            bad_q         <= bad_d;
            nblk_q        <= nblk_d;
            flush_cnt_q   <= flush_cnt_d;
            bios_we_q     <= bios_we_d;
            cart_we_q     <= cart_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            cart_loaded_q <= cart_loaded_d;
            st2_error_q   <= st2_error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (page_we) page_mem_q[ioctl_addr[5:0]] <= ioctl_dout[3:0];
    end

    assign ioctl_wait  = 1'b0;
    assign bios_we     = bios_we_q;
    assign cart_we     = cart_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign cart_loaded = cart_loaded_q;
    assign st2_error   = st2_error_q;
    assign cpu_reset   = reset | (state_q != IDLE);

endmodule

// File: tb/tb_st2_cart_loader.sv
// Directed bench for st2_cart_loader: BIOS, raw and .st2 downloads, header rejects,
// reset mid-body and unknown-index downloads, each write checked the cycle after it.
module tb_st2_cart_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        bios_we;
    logic        cart_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_din;
    logic        cpu_reset;
    logic        cart_loaded;
    logic        st2_error;

    int n_checks = 0;
    int n_fail   = 0;
    int n_bios   = 0;
    int n_cart   = 0;

    st2_cart_loader dut (
        .clk(clk), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .bios_we(bios_we),
        .cart_we(cart_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .cpu_reset(cpu_reset), .cart_loaded(cart_loaded), .st2_error(st2_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bios_we) n_bios++;
        if (cart_we) n_cart++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock with the given write; outputs checked at the following negedge.
    task automatic step(input string tag, input logic w, input int a, input logic [7:0] d,
                        input logic eb, input logic ec, input logic [11:0] ea);
        ioctl_wr   = w;
        ioctl_addr = 25'(a);
        ioctl_dout = d;
        @(negedge clk);
        if (eb || ec)
            check(tag, {10'd0, bios_we, cart_we, mem_addr, mem_din}, {10'd0, eb, ec, ea, d});
        else
            check(tag, {30'd0, bios_we, cart_we}, 32'd0);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        ioctl_wr       = 1'b0;
        @(negedge clk);
        check("cpu_reset_rise", 32'(cpu_reset), 32'd1);
    endtask

    task automatic end_dl();
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && cpu_reset; i++) @(negedge clk);
        check("idle_timeout", 32'(cpu_reset), 32'd0);
    endtask

    task automatic send_hdr(input logic [7:0] m3, input logic [7:0] nb, input logic [7:0] p0,
                            input logic [7:0] p1, input int upto);
        logic [31:0] magic;
        logic [7:0]  b;
        magic = {8'h52, 8'h43, 8'h41, m3};
        for (int a = 0; a < upto; a++) begin
            if (a < 4)       b = magic[31-8*a -: 8];
            else if (a == 4) b = nb;
            else if (a == 64) b = p0;
            else if (a == 65) b = p1;
            else             b = 8'h00;
            step("hdr_nowrite", 1'b1, a, b, 1'b0, 1'b0, 12'd0);
        end
    endtask

    initial begin
        int b0, c0;
        reset = 1'b1; ioctl_download = 1'b0; ioctl_index = 8'd0;
        ioctl_wr = 1'b0; ioctl_addr = 25'd0; ioctl_dout = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_outputs", {18'd0, bios_we, cart_we, mem_addr}, 32'd0);
        check("rst_din", 32'(mem_din), 32'd0);
        check("rst_flags", {29'd0, cart_loaded, st2_error, ioctl_wait}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_cpu_reset", 32'(cpu_reset), 32'd0);

        // BIOS image, 2048 bytes plus one out-of-range byte
        b0 = n_bios; c0 = n_cart;
        start_dl(8'd0);
        for (int a = 0; a < 2048; a++) step("bios_wr", 1'b1, a, 8'(a), 1'b1, 1'b0, 12'(a));
        step("bios_drop", 1'b1, 2048, 8'h77, 1'b0, 1'b0, 12'd0);
        end_dl();
        check("bios_count", 32'(n_bios - b0), 32'd2048);
        check("bios_no_cart", 32'(n_cart - c0), 32'd0);
        check("bios_loaded", 32'(cart_loaded), 32'd0);
        repeat (15) @(negedge clk);
        check("bios_hold16", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        check("bios_release17", 32'(cpu_reset), 32'd0);
        $display("bios download: %0d bios strobes", n_bios - b0);

        // Raw cartridge, 1024 bytes plus edge offsets
        c0 = n_cart;
        start_dl(8'd1);
        for (int a = 0; a < 1024; a++)
            step("bin_wr", 1'b1, a, 8'(a ^ 8'h3C), 1'b0, 1'b1, 12'h400 + 12'(a));
        step("bin_last_ok", 1'b1, 3071, 8'hA5, 1'b0, 1'b1, 12'hFFF);
        step("bin_drop", 1'b1, 3072, 8'h5A, 1'b0, 1'b0, 12'd0);
        end_dl();
        check("bin_count", 32'(n_cart - c0), 32'd1025);
        check("bin_loaded", {30'd0, cart_loaded, st2_error}, 32'd2);
        wait_idle();
        $display("bin download: %0d cart strobes", n_cart - c0);

        // Valid .st2, nblk=3, pages 04 and 0A
        c0 = n_cart;
        start_dl(8'd2);
        check("st2_entry_clear", 32'(cart_loaded), 32'd0);
        send_hdr(8'h32, 8'd3, 8'h04, 8'h0A, 256);
        check("st2_hdr_ok", 32'(st2_error), 32'd0);
        for (int a = 256; a < 768; a++)
            step("st2_body", 1'b1, a, 8'(a ^ 8'h5A), 1'b0, 1'b1,
                 (a < 512) ? {4'h4, 8'(a)} : {4'hA, 8'(a)});
        end_dl();
        check("st2_count", 32'(n_cart - c0), 32'd512);
        check("st2_flags", {30'd0, cart_loaded, st2_error}, 32'd2);
        wait_idle();
        $display("st2 download: %0d cart strobes", n_cart - c0);

        // Bad magic "RCA3"
        c0 = n_cart;
        start_dl(8'd2);
        check("rca3_loaded_clr", 32'(cart_loaded), 32'd0);
        send_hdr(8'h33, 8'd3, 8'h04, 8'h0A, 255);
        check("rca3_before255", 32'(st2_error), 32'd0);
        step("rca3_b255", 1'b1, 255, 8'h00, 1'b0, 1'b0, 12'd0);
        check("rca3_err_after255", 32'(st2_error), 32'd1);
        for (int a = 256; a < 512; a++) step("rca3_body", 1'b1, a, 8'(a), 1'b0, 1'b0, 12'd0);
        end_dl();
        check("rca3_no_writes", 32'(n_cart - c0), 32'd0);
        check("rca3_flags", {30'd0, cart_loaded, st2_error}, 32'd1);
        wait_idle();
        $display("rca3 download: rejected, %0d cart strobes", n_cart - c0);

        // nblk=2 with 768 bytes sent: only block 1 lands
        c0 = n_cart;
        start_dl(8'd2);
        check("nb2_err_clr", 32'(st2_error), 32'd0);
        send_hdr(8'h32, 8'd2, 8'h05, 8'h0B, 256);
        for (int a = 256; a < 768; a++)
            step("nb2_body", 1'b1, a, 8'(a + 7), 1'b0, a < 512, {4'h5, 8'(a)});
        end_dl();
        check("nb2_count", 32'(n_cart - c0), 32'd256);
        check("nb2_flags", {30'd0, cart_loaded, st2_error}, 32'd2);
        wait_idle();
        $display("st2 nblk=2 download: %0d cart strobes", n_cart - c0);

        // File shorter than the header
        start_dl(8'd2);
        send_hdr(8'h32, 8'd3, 8'h04, 8'h0A, 10);
        check("short_no_err_yet", 32'(st2_error), 32'd0);
        end_dl();
        check("short_flags", {30'd0, cart_loaded, st2_error}, 32'd1);
        wait_idle();
        $display("short st2 download: st2_error=%0d", st2_error);

        // nblk=1 is rejected at byte 255
        start_dl(8'd2);
        send_hdr(8'h32, 8'd1, 8'h04, 8'h0A, 256);
        check("nb1_err", 32'(st2_error), 32'd1);
        end_dl();
        wait_idle();
        $display("st2 nblk=1 download: st2_error=%0d", st2_error);

        // Reset in the middle of a body burst
        start_dl(8'd2);
        send_hdr(8'h32, 8'd3, 8'h06, 8'h07, 256);
        for (int a = 256; a < 300; a++)
            step("rstmid_body", 1'b1, a, 8'(a), 1'b0, 1'b1, {4'h6, 8'(a)});
        reset = 1'b1;
        step("rstmid_stop", 1'b1, 300, 8'h11, 1'b0, 1'b0, 12'd0);
        check("rstmid_cpu_reset", 32'(cpu_reset), 32'd1);
        reset = 1'b0;
        for (int a = 301; a < 321; a++) step("rstmid_ignored", 1'b1, a, 8'(a), 1'b0, 1'b0, 12'd0);
        check("rstmid_idle", {30'd0, cpu_reset, cart_loaded}, 32'd0);
        end_dl();
        @(negedge clk);
        check("rstmid_fall_idle", 32'(cpu_reset), 32'd0);
        $display("reset mid-body: writes stopped, cpu_reset=%0d", cpu_reset);

        // Unknown index 5: nothing written, CPU held
        b0 = n_bios; c0 = n_cart;
        start_dl(8'd5);
        for (int a = 0; a < 300; a++) step("idx5_skip", 1'b1, a, 8'(a), 1'b0, 1'b0, 12'd0);
        check("idx5_cpu_held", 32'(cpu_reset), 32'd1);
        end_dl();
        check("idx5_no_writes", 32'((n_bios - b0) + (n_cart - c0)), 32'd0);
        wait_idle();
        $display("index 5 download: skipped");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/st2_cart_loader.md
# st2_cart_loader

Download-side loader between the HPS ioctl stream and the rcastudioii core memories. It takes the byte stream from the ioctl bus and writes it into the 2 KB BIOS ROM or the 4 KB cartridge RAM. Raw .bin images load flat. .st2 images are parsed: the 256-byte header is checked and its page table is used to place each 256-byte block. While a download is in flight, the block holds the CPU in reset.

## Interface
Parameters
- BIOS_INDEX, 8'd0: ioctl_index value that selects the BIOS ROM image.
- BIN_INDEX, 8'd1: ioctl_index value that selects a raw cartridge, loaded flat from 12'h400.
- ST2_INDEX, 8'd2: ioctl_index value that selects an .st2 cartridge image.

Ports
- clk  in  1  system clock (clk_48 domain). One clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download active.
- ioctl_index  in  8  image type select.
- ioctl_wr  in  1  one-cycle strobe: ioctl_addr/ioctl_dout are valid.
- ioctl_addr  in  25  byte offset within the file.
- ioctl_dout  in  8  file data byte.
- ioctl_wait  out  1  always 0. Every write is absorbed in one cycle.
- bios_we  out  1  BIOS ROM write strobe.
- cart_we  out  1  cartridge RAM write strobe.
- mem_addr  out  12  write address, shared by both memories.
- mem_din  out  8  write data.
- cpu_reset  out  1  hold-off for the CDP1802/1861.
- cart_loaded  out  1  a cartridge loaded successfully.
- st2_error  out  1  the last .st2 image was rejected.

## Operation
- FSM states: IDLE, RAW, HDR, BODY, SKIP, FLUSH.
- IDLE, on the cycle ioctl_download rises:
  - index == BIOS_INDEX or BIN_INDEX → RAW.
  - index == ST2_INDEX → HDR.
  - any other index → SKIP.
  - On entry to RAW or HDR: clear cart_loaded and st2_error.
- RAW, on each ioctl_wr:
  - BIOS: mem_addr = ioctl_addr[10:0]. Writes with ioctl_addr ≥ 2048 are dropped.
  - BIN: mem_addr = 12'h400 + ioctl_addr[11:0], wrapping mod 4096. Writes with ioctl_addr ≥ 3072 are dropped.
- HDR, for ioctl_addr < 256:
  - Bytes 0–3 are compared against "RCA2" (52 43 41 32). Any mismatch sets the internal flag bad.
  - Byte 4 is latched as nblk, the block count including the header.
  - Bytes 64–127 are stored in page[0..63].
  - Nothing is written to memory.
  - The write with ioctl_addr == 255:
    - bad set → SKIP, st2_error=1.
    - nblk == 0 or nblk == 1 → SKIP, st2_error=1.
    - otherwise → BODY.
- BODY:
  - blk = ioctl_addr[13:8].
  - Write only when 1 ≤ blk < nblk and ioctl_addr < 16384.
  - mem_addr = {page[blk-1][3:0], ioctl_addr[7:0]}. page[x][7:4] is ignored.
  - Bytes beyond the last block are dropped.
- SKIP: all writes are ignored until the download ends.
- Download fall:
  - From RAW or BODY → FLUSH. For a cartridge image this sets cart_loaded=1.
  - From HDR, i.e. the file is shorter than 256 bytes → st2_error=1, then FLUSH.
  - From SKIP → FLUSH.
- FLUSH: counts 16 cycles, then → IDLE.
- cpu_reset = reset OR (state ≠ IDLE).
- Download rises again during FLUSH: treated exactly as a rise from IDLE; the flush count is abandoned.

## Timing
- Outputs bios_we, cart_we, mem_addr and mem_din are registered.
- A strobe is asserted exactly one cycle, the cycle after the ioctl_wr it serves, with address and data valid in that same cycle.
- Back-to-back ioctl_wr every cycle is supported: one strobe per cycle, no loss.
- cpu_reset rises the cycle after ioctl_download rises.
- cpu_reset falls 17 cycles after ioctl_download falls.
- cart_loaded and st2_error update the cycle after the download falls, except the header-reject case, where st2_error sets the cycle after byte 255.
- Reset values:
  - state IDLE.
  - All strobes 0; mem_addr and mem_din 0.
  - cart_loaded 0, st2_error 0, ioctl_wait 0.
  - cpu_reset 1 while reset is high.
  - page[] and nblk are don't-care.
- Reset mid-download: everything returns to IDLE immediately. A download still high after reset releases is ignored until it falls and rises again, because entry is edge-detected.
- ioctl_wr while ioctl_download is low is ignored.

## Test plan
- BIOS index 0, 2048 bytes, data = addr[7:0]:
  - 2048 bios_we pulses, last at mem_addr 12'h7FF, din 8'hFF.
  - No cart_we; cart_loaded stays 0.
  - cpu_reset falls 17 cycles after the download ends.
- BIN index 1, 1024 bytes:
  - First write at 12'h400, last at 12'h7FF.
  - A byte at offset 3072 produces no strobe.
  - cart_loaded=1.
- Valid .st2 with nblk=3, page[0]=8'h04, page[1]=8'h0A, 768 bytes:
  - Body lands at 12'h400–4FF and 12'hA00–AFF.
  - Header produces no writes; cart_loaded=1, st2_error=0.
- .st2 with magic "RCA3":
  - Zero cart_we pulses.
  - st2_error=1 the cycle after byte 255; cart_loaded=0.
- .st2 of nblk=2 with 768 bytes sent:
  - Only bytes 256–511 are written; bytes 512–767 are dropped.
- Reset asserted mid-BODY with ioctl_wr every cycle:
  - Strobes stop the next cycle.
  - After reset releases, no writes until ioctl_download toggles.
  - Index 5 download: no writes at all, and cpu_reset is still held.
